// File: rtl/mem_access_stage_if.sv
// ============================================================================
// Module : mem_access_stage_if
// Brief  : Data-memory request/acknowledge bus between the MEM stage and memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_access_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [3:0]        dm_sel;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;

    modport master (
        output dm_req, dm_we, dm_addr, dm_sel, dm_wdata,
        input  dm_rdata, dm_ack
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_sel, dm_wdata,
        output dm_rdata, dm_ack
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_stage.sv
// ============================================================================
// Module : mem_access_stage
// Brief  : MEM pipeline stage: big-endian byte/half/word loads and stores over
//          a req/ack bus, upstream stall, registered write-back outputs.
//          Optional macro MEM_UNALIGNED_EXC_EN adds the adel_exc output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_access_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic [4:0]        mem_wd,
    input  wire logic              mem_wreg,
    input  wire logic [DATA_W-1:0] mem_wdata,
    input  wire logic [3:0]        mem_op,
    input  wire logic [ADDR_W-1:0] mem_addr,
    input  wire logic [DATA_W-1:0] mem_sdata,
    mem_access_stage_if.master     dm,
    output logic                   stallreq,
`ifdef MEM_UNALIGNED_EXC_EN
    output logic                   adel_exc,
`endif
    output logic [4:0]             wb_wd,
    output logic                   wb_wreg,
    output logic [DATA_W-1:0]      wb_wdata
);

    localparam logic [3:0] c_OP_LB  = 4'd1;
    localparam logic [3:0] c_OP_LBU = 4'd2;
    localparam logic [3:0] c_OP_LH  = 4'd3;
    localparam logic [3:0] c_OP_LHU = 4'd4;
    localparam logic [3:0] c_OP_LW  = 4'd5;
    localparam logic [3:0] c_OP_SB  = 4'd6;
    localparam logic [3:0] c_OP_SH  = 4'd7;
    localparam logic [3:0] c_OP_SW  = 4'd8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_d;

    logic              r_dm_req;
    logic              r_dm_we;
    logic [ADDR_W-1:0] r_dm_addr;
    logic [3:0]        r_dm_sel;
    logic [DATA_W-1:0] r_dm_wdata;
    logic [3:0]        r_op;
    logic [1:0]        r_off;
    logic [4:0]        r_wd;
    logic              r_wreg;

    logic              w_is_mem;
    logic              w_is_store;
    logic              w_misaligned;
    logic              w_issue;
    logic [3:0]        w_sel;
    logic [DATA_W-1:0] w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load_data;

    assign dm.dm_req   = r_dm_req;
    assign dm.dm_we    = r_dm_we;
    assign dm.dm_addr  = r_dm_addr;
    assign dm.dm_sel   = r_dm_sel;
    assign dm.dm_wdata = r_dm_wdata;

    assign w_is_mem   = (mem_op >= c_OP_LB) && (mem_op <= c_OP_SW);
    assign w_is_store = (mem_op >= c_OP_SB) && (mem_op <= c_OP_SW);

`ifdef MEM_UNALIGNED_EXC_EN
    assign w_misaligned =
        (((mem_op == c_OP_LH) || (mem_op == c_OP_LHU) || (mem_op == c_OP_SH)) && mem_addr[0]) ||
        (((mem_op == c_OP_LW) || (mem_op == c_OP_SW)) && (mem_addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_issue = (r_state == IDLE) && w_is_mem && !w_misaligned;

    // Big-endian lanes: offset 0 is the most significant byte.
    always_comb begin
        w_sel   = 4'b1111;
        w_wdata = mem_sdata;
        case (mem_op)
            c_OP_LB, c_OP_LBU, c_OP_SB: begin
                w_sel   = 4'b1000 >> mem_addr[1:0];
                w_wdata = {4{mem_sdata[7:0]}};
            end
            c_OP_LH, c_OP_LHU, c_OP_SH: begin
                w_sel   = mem_addr[1] ? 4'b0011 : 4'b1100;
                w_wdata = {2{mem_sdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        case (r_off)
            2'd0:    w_byte = dm.dm_rdata[31:24];
            2'd1:    w_byte = dm.dm_rdata[23:16];
            2'd2:    w_byte = dm.dm_rdata[15:8];
            default: w_byte = dm.dm_rdata[7:0];
        endcase
        w_half = r_off[1] ? dm.dm_rdata[15:0] : dm.dm_rdata[31:16];

        w_load_data = dm.dm_rdata;
        case (r_op)
            c_OP_LB:  w_load_data = {{(DATA_W-8){w_byte[7]}}, w_byte};
            c_OP_LBU: w_load_data = {{(DATA_W-8){1'b0}}, w_byte};
            c_OP_LH:  w_load_data = {{(DATA_W-16){w_half[15]}}, w_half};
            c_OP_LHU: w_load_data = {{(DATA_W-16){1'b0}}, w_half};
            default:  w_load_data = dm.dm_rdata;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        stallreq  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_issue) begin
                    w_state_d = BUSY;
                    stallreq  = 1'b1;
                end
            end
            BUSY: begin
                // The ack cycle releases the stall so upstream advances in step.
                if (dm.dm_ack) begin
                    w_state_d = IDLE;
                end else begin
                    stallreq  = 1'b1;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dm_req   <= 1'b0;
            r_dm_we    <= 1'b0;
            r_dm_addr  <= '0;
            r_dm_sel   <= 4'b0000;
            r_dm_wdata <= '0;
            r_op       <= 4'd0;
            r_off      <= 2'd0;
            r_wd       <= 5'd0;
            r_wreg     <= 1'b0;
            wb_wd      <= 5'd0;
            wb_wreg    <= 1'b0;
            wb_wdata   <= '0;
`ifdef MEM_UNALIGNED_EXC_EN
            adel_exc   <= 1'b0;
`endif
        end else begin
`ifdef MEM_UNALIGNED_EXC_EN
            adel_exc <= (r_state == IDLE) && w_misaligned;
`endif
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_dm_req   <= 1'b1;
                        r_dm_we    <= w_is_store;
                        r_dm_addr  <= {mem_addr[ADDR_W-1:2], 2'b00};
                        r_dm_sel   <= w_sel;
                        r_dm_wdata <= w_wdata;
                        r_op       <= mem_op;
                        r_off      <= mem_addr[1:0];
                        r_wd       <= mem_wd;
                        r_wreg     <= mem_wreg;
                        wb_wreg    <= 1'b0;
                    end else begin
                        wb_wd    <= mem_wd;
                        wb_wreg  <= mem_wreg && !w_is_mem;
                        wb_wdata <= mem_wdata;
                    end
                end
                BUSY: begin
                    wb_wreg <= 1'b0;
                    if (dm.dm_ack) begin
                        r_dm_req <= 1'b0;
                        if (!r_dm_we) begin
                            wb_wd    <= r_wd;
                            wb_wreg  <= r_wreg;
                            wb_wdata <= w_load_data;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_stage.sv
// ============================================================================
// Module : tb_mem_access_stage
// Brief  : Directed vector bench for mem_access_stage with a scripted memory.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_sdata;
    logic        stallreq;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
`ifdef MEM_UNALIGNED_EXC_EN
    logic        adel_exc;
`endif

    int n_total = 0;
    int n_pass  = 0;

    mem_access_stage_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_access_stage #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .mem_op    (mem_op),
        .mem_addr  (mem_addr),
        .mem_sdata (mem_sdata),
        .dm        (bus.master),
        .stallreq  (stallreq),
`ifdef MEM_UNALIGNED_EXC_EN
        .adel_exc  (adel_exc),
`endif
        .wb_wd     (wb_wd),
        .wb_wreg   (wb_wreg),
        .wb_wdata  (wb_wdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        logic [3:0]  e_sel;
        logic [31:0] e_addr;
        logic [31:0] e_dwdata;
        logic        e_wreg;
        logic [31:0] e_wbdata;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic add(input string name, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] sdata, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] wdata, input int delay, input logic [31:0] rdata,
                       input logic [3:0] e_sel, input logic [31:0] e_addr,
                       input logic [31:0] e_dwdata, input logic e_wreg,
                       input logic [31:0] e_wbdata);
        vec_t v;
        v.name = name; v.op = op; v.addr = addr; v.sdata = sdata; v.wd = wd;
        v.wreg = wreg; v.wdata = wdata; v.delay = delay; v.rdata = rdata;
        v.e_sel = e_sel; v.e_addr = e_addr; v.e_dwdata = e_dwdata;
        v.e_wreg = e_wreg; v.e_wbdata = e_wbdata;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        mem_op = 4'd0; mem_wreg = 1'b0; mem_wd = 5'd0; mem_wdata = 32'd0;
        mem_addr = 32'd0; mem_sdata = 32'd0;
        bus.dm_ack = 1'b0; bus.dm_rdata = 32'd0;
    endtask

    // Called just after a rising edge; leaves the bench just after a later edge.
    task automatic run_vec(input vec_t v);
        logic is_mem, is_store;
        is_mem   = (v.op >= 4'd1) && (v.op <= 4'd8);
        is_store = (v.op >= 4'd6) && (v.op <= 4'd8);
        mem_op = v.op; mem_addr = v.addr; mem_sdata = v.sdata;
        mem_wd = v.wd; mem_wreg = v.wreg; mem_wdata = v.wdata;
        #1;
        chk({v.name, ".stall_issue"}, 32'(stallreq), 32'(is_mem));
        @(posedge clk); #1;
        if (!is_mem) begin
            chk({v.name, ".wb_wd"},    32'(wb_wd),   32'(v.wd));
            chk({v.name, ".wb_wreg"},  32'(wb_wreg), 32'(v.e_wreg));
            chk({v.name, ".wb_wdata"}, wb_wdata,     v.e_wbdata);
            chk({v.name, ".dm_req"},   32'(bus.dm_req), 32'd0);
        end else begin
            chk({v.name, ".dm_req"},   32'(bus.dm_req), 32'd1);
            chk({v.name, ".dm_we"},    32'(bus.dm_we),  32'(is_store));
            chk({v.name, ".dm_addr"},  bus.dm_addr,     v.e_addr);
            chk({v.name, ".dm_sel"},   32'(bus.dm_sel), 32'(v.e_sel));
            if (is_store) chk({v.name, ".dm_wdata"}, bus.dm_wdata, v.e_dwdata);
            chk({v.name, ".bubble"},   32'(wb_wreg), 32'd0);
            mem_op = 4'd0; mem_wreg = 1'b0;
            for (int i = 0; i < v.delay; i++) begin
                #1;
                chk({v.name, ".stall_wait"}, 32'(stallreq), 32'd1);
                @(posedge clk); #1;
                chk({v.name, ".hold_req"},  32'(bus.dm_req), 32'd1);
                chk({v.name, ".hold_addr"}, bus.dm_addr,     v.e_addr);
            end
            bus.dm_ack = 1'b1; bus.dm_rdata = v.rdata;
            #1;
            chk({v.name, ".stall_ack"}, 32'(stallreq), 32'd0);
            @(posedge clk); #1;
            bus.dm_ack = 1'b0; bus.dm_rdata = 32'hDEAD_0000;
            chk({v.name, ".req_drop"}, 32'(bus.dm_req), 32'd0);
            chk({v.name, ".wb_wreg"},  32'(wb_wreg),    32'(v.e_wreg));
            if (!is_store) begin
                chk({v.name, ".wb_wdata"}, wb_wdata,   v.e_wbdata);
                chk({v.name, ".wb_wd"},    32'(wb_wd), 32'(v.wd));
            end
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        //    name     op  addr       sdata         wd  wr wdata        dly rdata         sel      dm_addr      dm_wdata      ewr wb_wdata
        add("alu",     0, 32'h0,     32'h0,        5,  1, 32'h1234,    0, 32'h0,        4'b0000, 32'h0,       32'h0,        1, 32'h0000_1234);
        add("lb_m",    1, 32'h101,   32'h0,        7,  1, 32'h0,       3, 32'h00F00000, 4'b0100, 32'h100,     32'h0,        1, 32'hFFFF_FFF0);
        add("lhu_lo",  4, 32'h202,   32'h0,        8,  1, 32'h0,       0, 32'hAAAA8001, 4'b0011, 32'h200,     32'h0,        1, 32'h0000_8001);
        add("sb_3",    6, 32'h3,     32'h5A,       9,  1, 32'h0,       1, 32'h0,        4'b0001, 32'h0,       32'h5A5A5A5A, 0, 32'h0);
        add("lbu_0",   2, 32'h100,   32'h0,        10, 1, 32'h0,       0, 32'h80FFFFFF, 4'b1000, 32'h100,     32'h0,        1, 32'h0000_0080);
        add("lh_hi",   3, 32'h200,   32'h0,        11, 1, 32'h0,       2, 32'h8001AAAA, 4'b1100, 32'h200,     32'h0,        1, 32'hFFFF_8001);
        add("lw",      5, 32'h304,   32'h0,        12, 1, 32'h0,       0, 32'hDEADBEEF, 4'b1111, 32'h304,     32'h0,        1, 32'hDEAD_BEEF);
        add("sh_lo",   7, 32'h402,   32'h0000BEEF, 13, 1, 32'h0,       0, 32'h0,        4'b0011, 32'h400,     32'hBEEFBEEF, 0, 32'h0);
        add("sw",      8, 32'h500,   32'h12345678, 14, 1, 32'h0,       1, 32'h0,        4'b1111, 32'h500,     32'h12345678, 0, 32'h0);
        add("op12",    12, 32'h600,  32'h0,        3,  1, 32'h77,      0, 32'h0,        4'b0000, 32'h0,       32'h0,        1, 32'h0000_0077);
        add("lb_3",    1, 32'h103,   32'h0,        15, 1, 32'h0,       0, 32'hFFFFFF7F, 4'b0001, 32'h100,     32'h0,        1, 32'h0000_007F);
        add("lb_nowr", 1, 32'h102,   32'h0,        16, 0, 32'h0,       0, 32'h0000F100, 4'b0010, 32'h100,     32'h0,        0, 32'hFFFF_FFF1);
`ifndef MEM_UNALIGNED_EXC_EN
        add("lw_mis",  5, 32'h306,   32'h0,        17, 1, 32'h0,       0, 32'hCAFEF00D, 4'b1111, 32'h304,     32'h0,        1, 32'hCAFE_F00D);
        add("lh_mis",  3, 32'h201,   32'h0,        18, 1, 32'h0,       0, 32'h9000_1234, 4'b1100, 32'h200,    32'h0,        1, 32'hFFFF_9000);
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("rst.dm_req",   32'(bus.dm_req), 32'd0);
        chk("rst.stallreq", 32'(stallreq),   32'd0);
        chk("rst.wb_wreg",  32'(wb_wreg),    32'd0);
        chk("rst.wb_wdata", wb_wdata,        32'd0);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // An ack seen while IDLE must not disturb the passthrough path.
        mem_op = 4'd0; mem_wd = 5'd21; mem_wreg = 1'b1; mem_wdata = 32'h55;
        bus.dm_ack = 1'b1; bus.dm_rdata = 32'hFFFF_FFFF;
        #1;
        chk("idle_ack.stall", 32'(stallreq), 32'd0);
        @(posedge clk); #1;
        bus.dm_ack = 1'b0;
        chk("idle_ack.dm_req",   32'(bus.dm_req), 32'd0);
        chk("idle_ack.wb_wdata", wb_wdata,        32'h55);

        // Reset while BUSY abandons the access.
        mem_op = 4'd5; mem_addr = 32'h700; mem_wd = 5'd22; mem_wreg = 1'b1;
        @(posedge clk); #1;
        chk("rstbusy.issue", 32'(bus.dm_req), 32'd1);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstbusy.dm_req",   32'(bus.dm_req), 32'd0);
        chk("rstbusy.stallreq", 32'(stallreq),   32'd0);
        chk("rstbusy.wb_wd",    32'(wb_wd),      32'd0);
        chk("rstbusy.wb_wreg",  32'(wb_wreg),    32'd0);
        chk("rstbusy.wb_wdata", wb_wdata,        32'd0);
        mem_op = 4'd0; mem_wd = 5'd23; mem_wreg = 1'b1; mem_wdata = 32'hABCD;
        @(posedge clk); #1;
        chk("rstbusy.alu_wd",    32'(wb_wd),   32'd23);
        chk("rstbusy.alu_wreg",  32'(wb_wreg), 32'd1);
        chk("rstbusy.alu_wdata", wb_wdata,     32'hABCD);

`ifdef MEM_UNALIGNED_EXC_EN
        chk("adel.idle", 32'(adel_exc), 32'd0);
        mem_op = 4'd5; mem_addr = 32'h6; mem_wd = 5'd24; mem_wreg = 1'b1;
        #1;
        chk("adel.stall", 32'(stallreq), 32'd0);
        @(posedge clk); #1;
        chk("adel.dm_req",  32'(bus.dm_req), 32'd0);
        chk("adel.exc",     32'(adel_exc),   32'd1);
        chk("adel.wb_wreg", 32'(wb_wreg),    32'd0);
        mem_op = 4'd0; mem_wreg = 1'b0;
        @(posedge clk); #1;
        chk("adel.clear", 32'(adel_exc), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs (destination register, write enable, write data) plus the load/store controls.
- Performs data-memory loads and stores over a request/acknowledge bus and performs byte/halfword lane extraction.
- Stalls the upstream pipeline while an access is outstanding.
- Presents registered write-back results (wb_wd, wb_wreg, wb_wdata) to the MEM/WB side.

Parameters:
- ADDR_W, 32, data-memory byte-address width.
- DATA_W, 32, data-bus width (fixed 32; other values unsupported).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- mem_wd  in  5  destination register from EX/MEM
- mem_wreg  in  1  register write enable from EX/MEM
- mem_wdata  in  32  ALU result; passed through for non-memory ops
- mem_op  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none
- mem_addr  in  ADDR_W  effective byte address
- mem_sdata  in  32  store data, right-aligned
- dm_req  out  1  memory request, registered
- dm_we  out  1  1 = store
- dm_addr  out  ADDR_W  word address (byte address with [1:0] forced to 0)
- dm_sel  out  4  byte enables; bit3 = bits 31:24
- dm_wdata  out  32  lane-replicated store data
- dm_rdata  in  32  read data, valid when dm_ack=1
- dm_ack  in  1  single-cycle completion strobe
- stallreq  out  1  combinational; holds upstream stages
- wb_wd  out  5  registered
- wb_wreg  out  1  registered
- wb_wdata  out  32  registered

Behaviour:
- Reset values: all registered outputs 0; state IDLE. Reset mid-transaction drops dm_req at the next edge and abandons the access; the memory tolerates this.
- Endianness: big-endian lanes. addr[1:0]=0 selects bits 31:24; =3 selects bits 7:0. Halfword: addr[1]=0 selects bits 31:16.
- FSM states: IDLE, BUSY.
- IDLE, non-memory op: wb_* <= mem_* at the next edge (latency 1). stallreq=0.
- IDLE, memory op:
  - stallreq=1.
  - At the edge: dm_req<=1; dm_we, dm_addr, dm_sel, dm_wdata loaded; latch op, addr[1:0], wd, wreg; wb_wreg<=0 (bubble); go to BUSY.
- BUSY, dm_ack=0: hold all dm_* stable; stallreq=1; wb_wreg<=0.
- BUSY, dm_ack=1:
  - stallreq=0 in the same cycle so upstream advances.
  - At the edge: dm_req<=0; state<=IDLE.
  - Load: wb_wdata <= the extracted lane, sign-extended for LB/LH, zero-extended for LBU/LHU; wb_wreg <= latched wreg.
  - Store: wb_wreg<=0.
- dm_ack while in IDLE is ignored.
- Minimum memory-op latency is 2 cycles (issue edge + ack edge). No back-to-back issue: the edge after completion is always in IDLE.
- dm_sel encoding:
  - SB/LB/LBU: one-hot by addr[1:0].
  - SH/LH/LHU: 1100 for addr[1]=0, 0011 for addr[1]=1.
  - SW/LW: 1111.
- dm_wdata encoding: SB replicates byte ×4; SH replicates halfword ×2; SW unchanged.
- Misalignment without the feature: addr[0] is ignored for halfword ops and addr[1:0] is ignored for word ops.

Optional Feature:
- Macro: MEM_UNALIGNED_EXC_EN.
- When defined:
  - Adds output port adel_exc (1 bit, registered, reset 0).
  - An LH/LHU/SH with addr[0]=1, or an LW/SW with addr[1:0]≠0, issues no request: dm_req stays 0, stallreq=0, wb_wreg<=0, adel_exc<=1 for one cycle.
  - adel_exc is 0 otherwise.
- When undefined: the port is absent and misalignment follows the Behaviour section.

Test Plan:
- Reset, then mem_op=0, wd=5, wreg=1, wdata=0x1234 → next edge wb_wd=5, wb_wreg=1, wb_wdata=0x1234; stallreq=0 throughout.
- LB addr=0x101, ack 3 cycles after dm_req, dm_rdata=0x00F00000 → dm_sel=0100, dm_addr=0x100; stallreq high until the ack cycle; wb_wdata=0xFFFFFFF0.
- LHU addr=0x202, single-cycle ack, dm_rdata=0xAAAA8001 → dm_sel=0011; wb_wdata=0x00008001.
- SB addr=0x3, sdata=0x5A → dm_we=1, dm_sel=0001, dm_wdata=0x5A5A5A5A; wb_wreg=0 after the ack.
- Assert rst while BUSY with no ack → next edge dm_req=0, stallreq=0, wb_* all 0; a following ALU op passes through normally.
- With MEM_UNALIGNED_EXC_EN: LW addr=0x6 → dm_req stays 0, adel_exc=1 for one cycle, wb_wreg=0.
